dpram_fifo_ctrl: RTL and testbench
==================================

// Module: dpram_fifo_ctrl
// PURPOSE
//   FIFO controller sitting directly upstream of the synchronous dual-port RAM (64 x 16).
//   - Drives the RAM write port: write enable, write address, data.
//   - Drives the RAM read port address and consumes its registered read data.
//   - Turns the RAM into a first-in/first-out queue with full/empty flags and an occupancy count.
// PARAMETERS
//   DATA_WIDTH  16  word width; matches RAM data width
//   ADDR_WIDTH  6   RAM address width; DEPTH = 2**ADDR_WIDTH = 64 entries (localparam)
// PORTS
//   clockPulse         in   1             single system clock; all state on rising edge
//   reset              in   1             synchronous, active-high reset
//   push               in   1             write request
//   push_data          in   DATA_WIDTH    word to enqueue
//   pop                in   1             read request
//   pop_data           out  DATA_WIDTH    dequeued word; valid only while pop_valid=1
//   pop_valid          out  1             pop_data holds the word popped on the previous edge
//   full               out  1             count == DEPTH
//   empty              out  1             count == 0
//   count              out  ADDR_WIDTH+1  occupancy, 0..DEPTH
//   ram_writeEnable    out  1             to RAM writeEnable
//   ram_write_address  out  ADDR_WIDTH    to RAM first-port (write) address
//   ram_value          out  DATA_WIDTH    to RAM value
//   ram_read_address   out  ADDR_WIDTH    to RAM second-port address
//   ram_read_data      in   DATA_WIDTH    from RAM Second_Port_Output (1-cycle registered read)
//   error              out  1             sticky misuse flag (only with FIFO_ERROR_STICKY_EN)
// BEHAVIOUR
//   Reset values: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, pop_valid=0, error=0.
//   Combinational outputs:
//     - push_ok = push & ~full; pop_ok = pop & ~empty.
//     - ram_writeEnable = push_ok; ram_write_address = wr_ptr; ram_value = push_data.
//     - ram_read_address = rd_ptr; pop_data = ram_read_data.
//   On each edge with reset=0:
//     - push_ok: wr_ptr += 1, mod DEPTH; wraps 63 -> 0.
//     - pop_ok: rd_ptr += 1, mod DEPTH.
//     - count += push_ok - pop_ok; push_ok and pop_ok together leave count unchanged.
//     - empty and full are registered and updated from the next count value.
//     - pop_valid <= pop_ok.
//   Latency:
//     - Word pushed at edge k can be popped at edge k+1 at the earliest.
//     - A word popped at edge k appears on pop_data with pop_valid=1 between edges k and k+1.
//   Boundary conditions:
//     - Push while full is dropped, even when pop is also asserted; RAM is not written.
//       This prevents a read-during-write to the same address.
//     - Pop while empty is ignored, even when push is also asserted; there is no bypass.
//       The pop produces no pop_valid.
//     - Pointers never collide on a same-edge read/write except in the rejected cases above.
//     - Reset mid-operation: pointers and count return to 0 and a pending pop_valid is cleared.
//       RAM contents are untouched but become unreachable.
// CONFIGURATION
//   FIFO_ERROR_STICKY_EN defined:
//     - error <= 1 on any edge where push&full or pop&empty; holds until reset.
//   FIFO_ERROR_STICKY_EN undefined:
//     - error port is still present and tied to 0; no error logic is built.
// TESTING
//   1. Reset, then idle -> empty=1, full=0, count=0, pop_valid=0, ram_writeEnable=0.
//   2. Push 16'hB0CB, then pop next cycle -> ram_write_address=0 with writeEnable=1;
//      one cycle after the pop, pop_valid=1 and pop_data=16'hB0CB; count returns to 0.
//   3. Push 64 words 16'h0000..16'h003F -> full=1 and count=64 after the 64th edge;
//      a 65th push gives ram_writeEnable=0 and count stays 64; error=1 only with the macro.
//   4. From full, pop 64 words -> data 16'h0000..16'h003F in order and empty=1 at the end;
//      an extra pop gives no pop_valid.
//   5. Push 60 words, pop 60, push 10 -> ram_write_address wraps 63 -> 0,
//      and the next pops return the 10 words in order.
//   6. Count=5 with push+pop each cycle for 8 cycles -> count stays 5;
//      assert reset with a pop in flight -> pop_valid=0 and count=0 on the next edge.

Source files
------------

// File: rtl/dpram_fifo_ctrl_if.sv
// FIFO controller bus: user push/pop side plus the dual-port RAM ports.
// The controller takes the slave modport; the user/RAM side takes master.
interface dpram_fifo_ctrl_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 6
) ();

    logic                  push;
    logic [DATA_WIDTH-1:0] push_data;
    logic                  pop;
    logic [DATA_WIDTH-1:0] pop_data;
    logic                  pop_valid;
    logic                  full;
    logic                  empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  ram_writeEnable;
    logic [ADDR_WIDTH-1:0] ram_write_address;
    logic [DATA_WIDTH-1:0] ram_value;
    logic [ADDR_WIDTH-1:0] ram_read_address;
    logic [DATA_WIDTH-1:0] ram_read_data;
    logic                  error;

    modport slave (
        input  push,
        input  push_data,
        input  pop,
        input  ram_read_data,
        output pop_data,
        output pop_valid,
        output full,
        output empty,
        output count,
        output ram_writeEnable,
        output ram_write_address,
        output ram_value,
        output ram_read_address,
        output error
    );

    modport master (
        output push,
        output push_data,
        output pop,
        output ram_read_data,
        input  pop_data,
        input  pop_valid,
        input  full,
        input  empty,
        input  count,
        input  ram_writeEnable,
        input  ram_write_address,
        input  ram_value,
        input  ram_read_address,
        input  error
    );

endinterface

// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller over a synchronous 64x16 dual-port RAM with registered flags.
// Optional sticky misuse flag: define FIFO_ERROR_STICKY_EN.
module dpram_fifo_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 6
) (
    input logic              clockPulse,
    input logic              reset,
    dpram_fifo_ctrl_if.slave bus
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE_COUNT = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] ONE_PTR = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  empty_q, empty_d;
    logic                  full_q, full_d;
    logic                  pop_valid_q, pop_valid_d;

    logic                  push_ok;
    logic                  pop_ok;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] rd_data;

    // Flags are registered, so gating uses the flopped view of the queue.
    assign push_ok = bus.push & ~full_q;
    assign pop_ok  = bus.pop & ~empty_q;

    assign wr_data = bus.push_data;
    assign rd_data = bus.ram_read_data;

    assign bus.ram_writeEnable   = push_ok;
    assign bus.ram_write_address = wr_ptr_q;
    assign bus.ram_value         = wr_data;
    assign bus.ram_read_address  = rd_ptr_q;
    assign bus.pop_data          = rd_data;
    assign bus.pop_valid         = pop_valid_q;
    assign bus.full              = full_q;
    assign bus.empty             = empty_q;
    assign bus.count             = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + ONE_PTR;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + ONE_PTR;
        end
    end

    always_comb begin
        count_d = count_q;
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + ONE_COUNT;
            2'b01:   count_d = count_q - ONE_COUNT;
            default: count_d = count_q;
        endcase
        empty_d     = (count_d == '0);
        full_d      = (count_d == FULL_COUNT);
        pop_valid_d = pop_ok;
    end

    always_ff @(posedge clockPulse) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            pop_valid_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            empty_q     <= empty_d;
            full_q      <= full_d;
            pop_valid_q <= pop_valid_d;
        end
    end

`ifdef FIFO_ERROR_STICKY_EN
    logic error_q, error_d;

    always_comb begin
        error_d = error_q
                | (bus.push & full_q)
                | (bus.pop & empty_q);
    end

    always_ff @(posedge clockPulse) begin
        if (reset) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign bus.error = error_q;
`else
    assign bus.error = 1'b0;
`endif

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Directed bench for dpram_fifo_ctrl with a behavioural 64x16 registered-read RAM.
// Expected error level follows FIFO_ERROR_STICKY_EN.
module tb_dpram_fifo_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    logic [15:0] mem [0:63];
    logic [15:0] rdata;

`ifdef FIFO_ERROR_STICKY_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    dpram_fifo_ctrl_if #(.DATA_WIDTH(16), .ADDR_WIDTH(6)) bus ();

    dpram_fifo_ctrl dut (
        .clockPulse (clk),
        .reset      (rst),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.ram_writeEnable) begin
            mem[bus.ram_write_address] <= bus.ram_value;
        end
        rdata <= mem[bus.ram_read_address];
    end

    assign bus.ram_read_data = rdata;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        bus.push  = 1'b0;
        bus.pop   = 1'b0;
        bus.push_data = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // 1: reset / idle
        #1;
        chk("rst_empty", bus.empty, 1);
        chk("rst_full", bus.full, 0);
        chk("rst_count", bus.count, 0);
        chk("rst_pop_valid", bus.pop_valid, 0);
        chk("rst_we", bus.ram_writeEnable, 0);
        chk("rst_error", bus.error, 0);

        // 2: single push then pop
        bus.push = 1'b1;
        bus.push_data = 16'hB0CB;
        #1;
        chk("t2_we", bus.ram_writeEnable, 1);
        chk("t2_waddr", bus.ram_write_address, 0);
        chk("t2_wdata", bus.ram_value, 16'hB0CB);
        tick();
        bus.push = 1'b0;
        bus.pop  = 1'b1;
        #1;
        chk("t2_count1", bus.count, 1);
        chk("t2_empty0", bus.empty, 0);
        chk("t2_raddr", bus.ram_read_address, 0);
        tick();
        bus.pop = 1'b0;
        chk("t2_pop_valid", bus.pop_valid, 1);
        chk("t2_pop_data", bus.pop_data, 16'hB0CB);
        chk("t2_count0", bus.count, 0);
        chk("t2_empty1", bus.empty, 1);
        tick();
        chk("t2_pop_valid0", bus.pop_valid, 0);

        // 3: fill to 64, then overflow push
        for (int i = 0; i < 64; i++) begin
            bus.push = 1'b1;
            bus.push_data = 16'(i);
            #1;
            chk("t3_we", bus.ram_writeEnable, 1);
            chk("t3_waddr", bus.ram_write_address, 32'((i + 1) % 64));
            tick();
        end
        bus.push_data = 16'h0040;
        #1;
        chk("t3_full", bus.full, 1);
        chk("t3_count64", bus.count, 64);
        chk("t3_err_pre", bus.error, 0);
        chk("t3_we_full", bus.ram_writeEnable, 0);
        tick();
        bus.push = 1'b0;
        chk("t3_count_hold", bus.count, 64);
        chk("t3_full_hold", bus.full, 1);
        chk("t3_error", bus.error, 32'(ERR_EXP));

        // 4: drain 64, then pop while empty
        bus.pop = 1'b1;
        for (int i = 0; i < 64; i++) begin
            tick();
            chk("t4_valid", bus.pop_valid, 1);
            chk("t4_data", bus.pop_data, 32'(i));
        end
        bus.pop = 1'b0;
        chk("t4_empty", bus.empty, 1);
        chk("t4_count", bus.count, 0);
        chk("t4_full", bus.full, 0);
        bus.pop = 1'b1;
        tick();
        bus.pop = 1'b0;
        chk("t4_extra_valid", bus.pop_valid, 0);
        chk("t4_extra_count", bus.count, 0);

        // 5: pointer wrap (both pointers at 1 here)
        bus.push = 1'b1;
        for (int i = 0; i < 60; i++) begin
            bus.push_data = 16'(16'h0100 + i);
            tick();
        end
        bus.push = 1'b0;
        chk("t5_count60", bus.count, 60);
        bus.pop = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick();
            chk("t5_data60", bus.pop_data, 32'(16'h0100 + i));
        end
        bus.pop = 1'b0;
        chk("t5_empty", bus.empty, 1);
        bus.push = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.push_data = 16'(16'h0200 + i);
            #1;
            chk("t5_wrap_addr", bus.ram_write_address, 32'((61 + i) % 64));
            tick();
        end
        bus.push = 1'b0;
        chk("t5_count10", bus.count, 10);
        bus.pop = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t5_wrap_valid", bus.pop_valid, 1);
            chk("t5_wrap_data", bus.pop_data, 32'(16'h0200 + i));
        end
        bus.pop = 1'b0;
        chk("t5_empty_end", bus.empty, 1);

        // 6: steady push+pop at count 5, then reset with pop in flight
        bus.push = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.push_data = 16'(16'h0300 + i);
            tick();
        end
        chk("t6_count5", bus.count, 5);
        bus.pop = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.push_data = 16'(16'h0400 + i);
            tick();
            chk("t6_count_hold", bus.count, 5);
            chk("t6_data", bus.pop_data,
                (i < 5) ? 32'(16'h0300 + i) : 32'(16'h0400 + i - 5));
        end
        bus.push = 1'b0;
        chk("t6_inflight", bus.pop_valid, 1);
        rst = 1'b1;
        bus.pop = 1'b0;
        tick();
        chk("t6_rst_valid", bus.pop_valid, 0);
        chk("t6_rst_count", bus.count, 0);
        chk("t6_rst_empty", bus.empty, 1);
        chk("t6_rst_error", bus.error, 0);
        rst = 1'b0;
        tick();
        chk("t6_post_raddr", bus.ram_read_address, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
